// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - shared 640x480@60 raster constants and sync bundle type
package vga_timing_pkg;

  localparam int unsigned CNT_W = 10;

  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned H_FP_DEF     = 16;
  localparam int unsigned H_SYNC_DEF   = 96;
  localparam int unsigned H_BP_DEF     = 48;
  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned V_FP_DEF     = 10;
  localparam int unsigned V_SYNC_DEF   = 2;
  localparam int unsigned V_BP_DEF     = 33;

  function automatic int unsigned axis_total(input int unsigned active, input int unsigned fp,
                                             input int unsigned sync, input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  localparam int unsigned H_TOTAL_DEF = axis_total(H_ACTIVE_DEF, H_FP_DEF, H_SYNC_DEF, H_BP_DEF);
  localparam int unsigned V_TOTAL_DEF = axis_total(V_ACTIVE_DEF, V_FP_DEF, V_SYNC_DEF, V_BP_DEF);

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic video_on;
  } sync_bits_t;

  // Blanking-interval values: syncs deasserted, video off.
  localparam sync_bits_t SYNC_IDLE = '{hsync: 1'b1, vsync: 1'b1, video_on: 1'b0};

endpackage

// File: rtl/sync_delay_line.sv
// rtl/sync_delay_line.sv - enable-gated shift register; depth 0 is a pass-through
module sync_delay_line #(
  parameter int unsigned       WIDTH     = 3,
  parameter int unsigned       DEPTH     = 2,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             shift_en_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o
);

  if (DEPTH == 0) begin : g_bypass
    logic unused_ok;
    assign unused_ok = ^{clk_i, rst_ni, shift_en_i};
    assign data_o    = data_i;
  end else begin : g_pipe
    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int i = 0; i < int'(DEPTH); i++) stage_q[i] <= RESET_VAL;
      end else if (shift_en_i) begin
        stage_q[0] <= data_i;
        for (int i = 1; i < int'(DEPTH); i++) stage_q[i] <= stage_q[i-1];
      end
    end

    assign data_o = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - pixel divider, raster counters and registered sync/video decode
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = H_ACTIVE_DEF,
  parameter int unsigned H_FP       = H_FP_DEF,
  parameter int unsigned H_SYNC     = H_SYNC_DEF,
  parameter int unsigned H_BP       = H_BP_DEF,
  parameter int unsigned V_ACTIVE   = V_ACTIVE_DEF,
  parameter int unsigned V_FP       = V_FP_DEF,
  parameter int unsigned V_SYNC     = V_SYNC_DEF,
  parameter int unsigned V_BP       = V_BP_DEF,
  parameter int unsigned CLK_DIV    = 2,
  parameter int unsigned SYNC_DELAY = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             pixel_tick,
  output logic [CNT_W-1:0] pixel_x,
  output logic [CNT_W-1:0] pixel_y,
  output logic             video_on,
  output logic             hsync,
  output logic             vsync,
  output logic             frame_start,
  output logic             hsync_d,
  output logic             vsync_d,
  output logic             video_on_d
);

  localparam int unsigned H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  if (H_TOTAL > (1 << CNT_W) || V_TOTAL > (1 << CNT_W) || CLK_DIV == 0) begin : g_param_check
    $fatal(1, "vga_timing_gen: raster totals must fit %0d-bit counters and CLK_DIV must be >= 1",
           CNT_W);
  end

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);

  // Decode bounds carry one spare bit so a 1024-wide axis compares correctly.
  localparam logic [CNT_W:0] H_ACT_LIM = (CNT_W+1)'(H_ACTIVE);
  localparam logic [CNT_W:0] HS_BEG    = (CNT_W+1)'(H_ACTIVE + H_FP);
  localparam logic [CNT_W:0] HS_END    = (CNT_W+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W:0] V_ACT_LIM = (CNT_W+1)'(V_ACTIVE);
  localparam logic [CNT_W:0] VS_BEG    = (CNT_W+1)'(V_ACTIVE + V_FP);
  localparam logic [CNT_W:0] VS_END    = (CNT_W+1)'(V_ACTIVE + V_FP + V_SYNC);

  logic [DIV_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] x_q, x_d, y_q, y_d;
  logic             tick_q, tick_d;
  logic             hs_q, hs_d, vs_q, vs_d, vid_q, vid_d, fs_q, fs_d;
  logic [CNT_W:0]   x_ext, y_ext;

  always_comb begin
    tick_d = (div_q == DIV_LAST);
    div_d  = tick_d ? '0 : div_q + 1'b1;
    x_d    = x_q;
    y_d    = y_q;
    if (tick_d) begin
      if (x_q == H_LAST) begin
        x_d = '0;
        y_d = (y_q == V_LAST) ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
    // Decode from the next position so flags land on the same edge as the counters.
    x_ext = {1'b0, x_d};
    y_ext = {1'b0, y_d};
    hs_d  = !((x_ext >= HS_BEG) && (x_ext < HS_END));
    vs_d  = !((y_ext >= VS_BEG) && (y_ext < VS_END));
    vid_d = (x_ext < H_ACT_LIM) && (y_ext < V_ACT_LIM);
    fs_d  = tick_d && (x_q == H_LAST) && (y_q == V_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q  <= '0;
      x_q    <= H_LAST;
      y_q    <= V_LAST;
      tick_q <= 1'b0;
      hs_q   <= SYNC_IDLE.hsync;
      vs_q   <= SYNC_IDLE.vsync;
      vid_q  <= SYNC_IDLE.video_on;
      fs_q   <= 1'b0;
    end else begin
      div_q  <= div_d;
      x_q    <= x_d;
      y_q    <= y_d;
      tick_q <= tick_d;
      hs_q   <= hs_d;
      vs_q   <= vs_d;
      vid_q  <= vid_d;
      fs_q   <= fs_d;
    end
  end

  sync_bits_t sync_now, sync_late;
  assign sync_now = '{hsync: hs_q, vsync: vs_q, video_on: vid_q};

  // Shifting on the same edge that advances the counters keeps the lag an exact tick count.
  sync_delay_line #(
    .WIDTH     ($bits(sync_bits_t)),
    .DEPTH     (SYNC_DELAY),
    .RESET_VAL (SYNC_IDLE)
  ) u_sync_delay (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .shift_en_i (tick_d),
    .data_i     (sync_now),
    .data_o     (sync_late)
  );

  assign pixel_tick  = tick_q;
  assign pixel_x     = x_q;
  assign pixel_y     = y_q;
  assign hsync       = hs_q;
  assign vsync       = vs_q;
  assign video_on    = vid_q;
  assign frame_start = fs_q;
  assign hsync_d     = sync_late.hsync;
  assign vsync_d     = sync_late.vsync;
  assign video_on_d  = sync_late.video_on;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - scoreboard bench: default raster plus two reduced rasters
module tb_vga_timing_gen;

  typedef struct packed {
    int ha, hf, hs, hb, va, vf, vs, vb, cd, sd;
  } geom_t;

  typedef struct packed {
    logic       tick;
    logic [9:0] x;
    logic [9:0] y;
    logic       hs, vs, vid, fs, hsd, vsd, vidd;
  } obs_t;

  localparam geom_t GA = '{640, 16, 96, 48, 480, 10, 2, 33, 2, 2};
  localparam geom_t GB = '{16, 2, 4, 3, 8, 2, 2, 3, 2, 0};
  localparam geom_t GC = '{16, 2, 4, 3, 8, 2, 2, 3, 1, 2};

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       a_tick, a_hs, a_vs, a_vid, a_fs, a_hsd, a_vsd, a_vidd;
  logic       b_tick, b_hs, b_vs, b_vid, b_fs, b_hsd, b_vsd, b_vidd;
  logic       c_tick, c_hs, c_vs, c_vid, c_fs, c_hsd, c_vsd, c_vidd;
  logic [9:0] a_x, a_y, b_x, b_y, c_x, c_y;
  obs_t       obs_a, obs_b, obs_c;

  assign obs_a = {a_tick, a_x, a_y, a_hs, a_vs, a_vid, a_fs, a_hsd, a_vsd, a_vidd};
  assign obs_b = {b_tick, b_x, b_y, b_hs, b_vs, b_vid, b_fs, b_hsd, b_vsd, b_vidd};
  assign obs_c = {c_tick, c_x, c_y, c_hs, c_vs, c_vid, c_fs, c_hsd, c_vsd, c_vidd};

  vga_timing_gen #(
    .H_ACTIVE(GA.ha), .H_FP(GA.hf), .H_SYNC(GA.hs), .H_BP(GA.hb),
    .V_ACTIVE(GA.va), .V_FP(GA.vf), .V_SYNC(GA.vs), .V_BP(GA.vb),
    .CLK_DIV(GA.cd), .SYNC_DELAY(GA.sd)
  ) u_dut_a (
    .clk(clk), .rst_n(rst_n), .pixel_tick(a_tick), .pixel_x(a_x), .pixel_y(a_y),
    .video_on(a_vid), .hsync(a_hs), .vsync(a_vs), .frame_start(a_fs),
    .hsync_d(a_hsd), .vsync_d(a_vsd), .video_on_d(a_vidd)
  );

  vga_timing_gen #(
    .H_ACTIVE(GB.ha), .H_FP(GB.hf), .H_SYNC(GB.hs), .H_BP(GB.hb),
    .V_ACTIVE(GB.va), .V_FP(GB.vf), .V_SYNC(GB.vs), .V_BP(GB.vb),
    .CLK_DIV(GB.cd), .SYNC_DELAY(GB.sd)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_n), .pixel_tick(b_tick), .pixel_x(b_x), .pixel_y(b_y),
    .video_on(b_vid), .hsync(b_hs), .vsync(b_vs), .frame_start(b_fs),
    .hsync_d(b_hsd), .vsync_d(b_vsd), .video_on_d(b_vidd)
  );

  vga_timing_gen #(
    .H_ACTIVE(GC.ha), .H_FP(GC.hf), .H_SYNC(GC.hs), .H_BP(GC.hb),
    .V_ACTIVE(GC.va), .V_FP(GC.vf), .V_SYNC(GC.vs), .V_BP(GC.vb),
    .CLK_DIV(GC.cd), .SYNC_DELAY(GC.sd)
  ) u_dut_c (
    .clk(clk), .rst_n(rst_n), .pixel_tick(c_tick), .pixel_x(c_x), .pixel_y(c_y),
    .video_on(c_vid), .hsync(c_hs), .vsync(c_vs), .frame_start(c_fs),
    .hsync_d(c_hsd), .vsync_d(c_vsd), .video_on_d(c_vidd)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Position index after k ticks; k<=0 means still parked at the last raster position.
  function automatic int pos_idx(input int k, input int ft);
    return (k <= 0) ? ft - 1 : (k - 1) % ft;
  endfunction

  function automatic logic [2:0] decode(input geom_t g, input int x, input int y);
    logic hs, vs, vid;
    hs  = !(x >= g.ha + g.hf && x < g.ha + g.hf + g.hs);
    vs  = !(y >= g.va + g.vf && y < g.va + g.vf + g.vs);
    vid = (x < g.ha) && (y < g.va);
    return {hs, vs, vid};
  endfunction

  // Expected outputs n clk edges after reset release, derived in closed form.
  function automatic obs_t model(input geom_t g, input int n);
    obs_t e;
    int   ht, vt, ft, k, p, pd;
    ht = g.ha + g.hf + g.hs + g.hb;
    vt = g.va + g.vf + g.vs + g.vb;
    ft = ht * vt;
    k  = n / g.cd;
    p  = pos_idx(k, ft);
    pd = pos_idx(k - g.sd, ft);
    e.tick = (n > 0) && (n % g.cd == 0);
    e.x    = 10'(p % ht);
    e.y    = 10'(p / ht);
    {e.hs, e.vs, e.vid}    = decode(g, p % ht, p / ht);
    {e.hsd, e.vsd, e.vidd} = decode(g, pd % ht, pd / ht);
    e.fs   = e.tick && (k >= 1) && ((k - 1) % ft == 0);
    return e;
  endfunction

  task automatic cmp(input string who, input obs_t o, input obs_t e);
    check({who, "_tick"},  32'(o.tick), 32'(e.tick));
    check({who, "_x"},     32'(o.x),    32'(e.x));
    check({who, "_y"},     32'(o.y),    32'(e.y));
    check({who, "_hsync"}, 32'(o.hs),   32'(e.hs));
    check({who, "_vsync"}, 32'(o.vs),   32'(e.vs));
    check({who, "_video"}, 32'(o.vid),  32'(e.vid));
    check({who, "_fstart"},32'(o.fs),   32'(e.fs));
    check({who, "_hsd"},   32'(o.hsd),  32'(e.hsd));
    check({who, "_vsd"},   32'(o.vsd),  32'(e.vsd));
    check({who, "_vidd"},  32'(o.vidd), 32'(e.vidd));
  endtask

  obs_t q_a[$], q_b[$], q_c[$];
  int   n_clk = 0;

  initial begin
    forever begin
      @(posedge clk);
      if (rst_n) n_clk++;
      else n_clk = 0;
      q_a.push_back(model(GA, n_clk));
      q_b.push_back(model(GB, n_clk));
      q_c.push_back(model(GC, n_clk));
    end
  end

  obs_t a_prev;
  int   a_hits = 0, a_hs_cnt = 0, a_hsd_cnt = 0;
  bit   hs_fall_done = 0, hs_cnt_on = 0, hsd_fall_done = 0, hsd_cnt_on = 0;
  bit   vid_fall_done = 0, wrap_done = 0;
  int   b_last = 0, c_last = 0, b_per = 0, c_per = 0;
  bit   b_valid = 0, c_valid = 0;

  initial begin
    a_prev = model(GA, 0);
    forever begin
      @(negedge clk);
      if (q_a.size() > 0) cmp("a", obs_a, q_a.pop_front());
      if (q_b.size() > 0) cmp("b", obs_b, q_b.pop_front());
      if (q_c.size() > 0) cmp("c", obs_c, q_c.pop_front());

      if (!hs_fall_done && a_prev.hs && !obs_a.hs) begin
        check("a_hsync_fall_x", 32'(obs_a.x), 656);
        hs_fall_done = 1; hs_cnt_on = 1; a_hs_cnt = 0; a_hits++;
      end
      if (hs_cnt_on && obs_a.tick && !obs_a.hs) a_hs_cnt++;
      if (hs_cnt_on && !a_prev.hs && obs_a.hs) begin
        check("a_hsync_width", 32'(a_hs_cnt), 96);
        hs_cnt_on = 0; a_hits++;
      end
      if (!hsd_fall_done && a_prev.hsd && !obs_a.hsd) begin
        check("a_hsync_d_fall_x", 32'(obs_a.x), 658);
        hsd_fall_done = 1; hsd_cnt_on = 1; a_hsd_cnt = 0; a_hits++;
      end
      if (hsd_cnt_on && obs_a.tick && !obs_a.hsd) a_hsd_cnt++;
      if (hsd_cnt_on && !a_prev.hsd && obs_a.hsd) begin
        check("a_hsync_d_width", 32'(a_hsd_cnt), 96);
        hsd_cnt_on = 0; a_hits++;
      end
      if (!vid_fall_done && a_prev.vid && !obs_a.vid) begin
        check("a_video_fall_x", 32'(obs_a.x), 640);
        vid_fall_done = 1; a_hits++;
      end
      if (!wrap_done && a_prev.x == 10'd799 && obs_a.x == 10'd0 && a_prev.y == 10'd0) begin
        check("a_y_after_wrap", 32'(obs_a.y), 1);
        wrap_done = 1; a_hits++;
      end
      a_prev = obs_a;

      if (!rst_n) begin
        b_valid = 0; c_valid = 0;
      end else begin
        if (obs_b.fs) begin
          if (b_valid) begin
            check("b_frame_period", 32'(n_clk - b_last), 25 * 15 * 2);
            b_per++;
          end
          b_last = n_clk; b_valid = 1;
        end
        if (obs_c.fs) begin
          if (c_valid) begin
            check("c_frame_period", 32'(n_clk - c_last), 25 * 15 * 1);
            c_per++;
          end
          c_last = n_clk; c_valid = 1;
        end
      end
    end
  end

  task automatic check_reset(input string tag);
    cmp({tag, "_a"}, obs_a, '{1'b0, 10'd799, 10'd524, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0});
    cmp({tag, "_b"}, obs_b, '{1'b0, 10'd24, 10'd14, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0});
    cmp({tag, "_c"}, obs_c, '{1'b0, 10'd24, 10'd14, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0});
  endtask

  initial begin
    bit found;
    repeat (3) @(negedge clk);
    #1 check_reset("por");
    #1 rst_n = 1'b1;
    repeat (2000) @(negedge clk);

    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (obs_b.x == 10'd19 && !obs_b.hs) found = 1;
    end
    check("b_midline_reached", 32'(found), 1);
    #2 rst_n = 1'b0;
    #1 check_reset("mid");
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (1200) @(negedge clk);

    check("a_line_events", 32'(a_hits), 6);
    check("b_periods_seen", 32'(b_per >= 2), 1);
    check("c_periods_seen", 32'(c_per >= 4), 1);
    check("queues_drained", 32'(q_a.size() + q_b.size() + q_c.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
